// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port register file with a per-register busy scoreboard,
// fixed write-port priority (highest index wins), optional bypass and zero register.
module reg_file_sb #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    i_rd_addr,
    output logic [NRD*WIDTH-1:0] o_rd_data,
    output logic [NRD-1:0]       o_rd_busy,
    input  logic [NWR-1:0]       i_wr_en,
    input  logic [NWR*AW-1:0]    i_wr_addr,
    input  logic [NWR*WIDTH-1:0] i_wr_data,
    input  logic [NWR-1:0]       i_wr_clr,
    input  logic                 i_rsv_en,
    input  logic [AW-1:0]        i_rsv_addr,
    output logic [DEPTH-1:0]     o_busy_vec,
    output logic                 o_wr_conflict
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic             r_conflict;
    logic [AW-1:0]    w_ra [NRD];
    logic [AW-1:0]    w_wa [NWR];
    logic [NWR-1:0]   w_wr_hit;
    logic [NWR-1:0]   w_wr_ok;
    logic [DEPTH-1:0] w_set, w_clr, w_busy_nxt;
    logic             w_conflict;

    always_comb begin
        for (int p = 0; p < NRD; p++) w_ra[p] = i_rd_addr[p*AW +: AW];
        for (int p = 0; p < NWR; p++) w_wa[p] = i_wr_addr[p*AW +: AW];
    end

    // w_wr_hit: enabled and in range (counts for conflicts); w_wr_ok: actually stores
    always_comb begin
        w_wr_hit   = '0;
        w_wr_ok    = '0;
        w_set      = '0;
        w_clr      = '0;
        w_conflict = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            w_wr_hit[p] = i_wr_en[p] && (int'(w_wa[p]) < DEPTH);
            w_wr_ok[p]  = w_wr_hit[p] && !(ZERO_R0 != 0 && w_wa[p] == '0);
            if (w_wr_ok[p]) w_clr[w_wa[p]] = i_wr_clr[p];
        end
        for (int p = 0; p < NWR; p++)
            for (int q = p + 1; q < NWR; q++)
                if (w_wr_hit[p] && w_wr_hit[q] && w_wa[p] == w_wa[q]) w_conflict = 1'b1;
        if (i_rsv_en && int'(i_rsv_addr) < DEPTH && !(ZERO_R0 != 0 && i_rsv_addr == '0))
            w_set[i_rsv_addr] = 1'b1;
        w_busy_nxt = (r_busy | w_set) & ~(w_clr & ~w_set);
    end

    // Busy is never bypassed; only data forwards from the winning write port
    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (int'(w_ra[p]) < DEPTH) begin
                o_rd_busy[p] = r_busy[w_ra[p]];
                if (!(ZERO_R0 != 0 && w_ra[p] == '0)) begin
                    o_rd_data[p*WIDTH +: WIDTH] = r_mem[w_ra[p]];
                    if (BYPASS != 0)
                        for (int q = 0; q < NWR; q++)
                            if (w_wr_ok[q] && w_wa[q] == w_ra[p])
                                o_rd_data[p*WIDTH +: WIDTH] = i_wr_data[q*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_busy     <= '0;
            r_conflict <= 1'b0;
        end else begin
            for (int p = 0; p < NWR; p++)
                if (w_wr_ok[p]) r_mem[w_wa[p]] <= i_wr_data[p*WIDTH +: WIDTH];
            r_busy     <= w_busy_nxt;
            r_conflict <= w_conflict;
        end
    end

    assign o_busy_vec    = r_busy;
    assign o_wr_conflict = r_conflict;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench over three configurations of reg_file_sb
// (bypass, no bypass, and a 16x12 4R3W zero-register sweep).
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] q[$];
    logic [63:0] exp_v;

    logic [7:0]  a_rd_addr, b_rd_addr, a_wr_addr, b_wr_addr;
    logic [63:0] a_rd_data, b_rd_data, a_wr_data, b_wr_data;
    logic [1:0]  a_rd_busy, b_rd_busy, a_wr_en, b_wr_en, a_wr_clr, b_wr_clr;
    logic        a_rsv_en, b_rsv_en, a_wr_conflict, b_wr_conflict;
    logic [3:0]  a_rsv_addr, b_rsv_addr;
    logic [15:0] a_busy_vec, b_busy_vec;

    logic [15:0] c_rd_addr;
    logic [63:0] c_rd_data;
    logic [3:0]  c_rd_busy, c_rsv_addr;
    logic [2:0]  c_wr_en, c_wr_clr;
    logic [11:0] c_wr_addr, c_busy_vec;
    logic [47:0] c_wr_data;
    logic        c_rsv_en, c_wr_conflict;

    logic [15:0] m_mem [12];
    logic [11:0] m_busy;
    logic        m_conf;

    reg_file_sb #(.BYPASS(1), .ZERO_R0(0)) u_a (
        .clk(clk), .rst_n(rst_n), .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data),
        .o_rd_busy(a_rd_busy), .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr),
        .i_wr_data(a_wr_data), .i_wr_clr(a_wr_clr), .i_rsv_en(a_rsv_en),
        .i_rsv_addr(a_rsv_addr), .o_busy_vec(a_busy_vec), .o_wr_conflict(a_wr_conflict));

    reg_file_sb #(.BYPASS(0), .ZERO_R0(0)) u_b (
        .clk(clk), .rst_n(rst_n), .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data),
        .o_rd_busy(b_rd_busy), .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr),
        .i_wr_data(b_wr_data), .i_wr_clr(b_wr_clr), .i_rsv_en(b_rsv_en),
        .i_rsv_addr(b_rsv_addr), .o_busy_vec(b_busy_vec), .o_wr_conflict(b_wr_conflict));

    reg_file_sb #(.WIDTH(16), .DEPTH(12), .NRD(4), .NWR(3), .ZERO_R0(1), .BYPASS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .i_rd_addr(c_rd_addr), .o_rd_data(c_rd_data),
        .o_rd_busy(c_rd_busy), .i_wr_en(c_wr_en), .i_wr_addr(c_wr_addr),
        .i_wr_data(c_wr_data), .i_wr_clr(c_wr_clr), .i_rsv_en(c_rsv_en),
        .i_rsv_addr(c_rsv_addr), .o_busy_vec(c_busy_vec), .o_wr_conflict(c_wr_conflict));

    task automatic idle();
        a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0; a_wr_clr = '0;
        a_rsv_en = 1'b0; a_rsv_addr = '0;
        b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_wr_clr = '0;
        b_rsv_en = 1'b0; b_rsv_addr = '0;
        c_rd_addr = '0; c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0; c_wr_clr = '0;
        c_rsv_en = 1'b0; c_rsv_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        q.push_back(64'h0); q.push_back(64'h0); q.push_back(64'h0); q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (a_rd_data !== exp_v) begin miscompares++; $display("FAIL reset_rd_data got %h want %h", a_rd_data, exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(a_busy_vec) !== exp_v) begin miscompares++; $display("FAIL reset_busy_a got %h want %h", a_busy_vec, exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(c_busy_vec) !== exp_v) begin miscompares++; $display("FAIL reset_busy_c got %h want %h", c_busy_vec, exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(a_wr_conflict) !== exp_v) begin miscompares++; $display("FAIL reset_conflict got %h want %h", a_wr_conflict, exp_v); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        a_wr_en = 2'b01; a_wr_addr = 8'h03; a_wr_data = 64'hDEADBEEF; a_rsv_en = 1'b1; a_rsv_addr = 4'd3;
        @(negedge clk);
        idle(); a_rd_addr = 8'h03;
        q.push_back(64'hDEADBEEF); q.push_back(64'h0008);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_rd_data[31:0]) !== exp_v) begin miscompares++; $display("FAIL pre_reset_r3 got %h want %h", a_rd_data[31:0], exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(a_busy_vec) !== exp_v) begin miscompares++; $display("FAIL pre_reset_busy got %h want %h", a_busy_vec, exp_v); end
        rst_n = 1'b0;
        q.push_back(64'h0); q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_rd_data[31:0]) !== exp_v) begin miscompares++; $display("FAIL async_reset_rd got %h want %h", a_rd_data[31:0], exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(a_busy_vec) !== exp_v) begin miscompares++; $display("FAIL async_reset_busy got %h want %h", a_busy_vec, exp_v); end
        a_wr_en = 2'b01; a_wr_addr = 8'h03; a_wr_data = 64'h1234; a_rsv_en = 1'b1; a_rsv_addr = 4'd3;
        @(negedge clk);
        idle(); rst_n = 1'b1; a_rd_addr = 8'h03;
        q.push_back(64'h0); q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_rd_data[31:0]) !== exp_v) begin miscompares++; $display("FAIL post_reset_r3 got %h want %h", a_rd_data[31:0], exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(a_busy_vec) !== exp_v) begin miscompares++; $display("FAIL post_reset_busy got %h want %h", a_busy_vec, exp_v); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        a_wr_en = 2'b01; a_wr_addr = 8'h05; a_wr_data = 64'h12345678; a_rd_addr = 8'h50;
        b_wr_en = 2'b01; b_wr_addr = 8'h05; b_wr_data = 64'h12345678; b_rd_addr = 8'h50;
        q.push_back(64'h12345678); q.push_back(64'h0); q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_rd_data[63:32]) !== exp_v) begin miscompares++; $display("FAIL bypass_same_cycle got %h want %h", a_rd_data[63:32], exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(b_rd_data[63:32]) !== exp_v) begin miscompares++; $display("FAIL nobypass_same_cycle got %h want %h", b_rd_data[63:32], exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(a_rd_busy) !== exp_v) begin miscompares++; $display("FAIL bypass_busy got %h want %h", a_rd_busy, exp_v); end
        @(negedge clk);
        idle(); a_rd_addr = 8'h50; b_rd_addr = 8'h50;
        q.push_back(64'h12345678); q.push_back(64'h12345678);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_rd_data[63:32]) !== exp_v) begin miscompares++; $display("FAIL bypass_next_cycle got %h want %h", a_rd_data[63:32], exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(b_rd_data[63:32]) !== exp_v) begin miscompares++; $display("FAIL nobypass_next_cycle got %h want %h", b_rd_data[63:32], exp_v); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        idle();
        a_wr_en = 2'b11; a_wr_addr = 8'h77; a_wr_data = {32'h2, 32'h1}; a_rd_addr = 8'h07;
        b_wr_en = 2'b11; b_wr_addr = 8'h77; b_wr_data = {32'h2, 32'h1};
        q.push_back(64'h2); q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_rd_data[31:0]) !== exp_v) begin miscompares++; $display("FAIL collide_bypass got %h want %h", a_rd_data[31:0], exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(a_wr_conflict) !== exp_v) begin miscompares++; $display("FAIL collide_conflict_early got %h want %h", a_wr_conflict, exp_v); end
        @(negedge clk);
        idle(); a_rd_addr = 8'h07; b_rd_addr = 8'h07;
        q.push_back(64'h2); q.push_back(64'h2); q.push_back(64'h1); q.push_back(64'h1);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_rd_data[31:0]) !== exp_v) begin miscompares++; $display("FAIL collide_a_r7 got %h want %h", a_rd_data[31:0], exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(b_rd_data[31:0]) !== exp_v) begin miscompares++; $display("FAIL collide_b_r7 got %h want %h", b_rd_data[31:0], exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(a_wr_conflict) !== exp_v) begin miscompares++; $display("FAIL collide_conflict_a got %h want %h", a_wr_conflict, exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(b_wr_conflict) !== exp_v) begin miscompares++; $display("FAIL collide_conflict_b got %h want %h", b_wr_conflict, exp_v); end
        @(negedge clk);
        idle();
        a_wr_en = 2'b11; a_wr_addr = 8'h87; a_wr_data = {32'h22, 32'h11};
        q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_wr_conflict) !== exp_v) begin miscompares++; $display("FAIL conflict_one_cycle got %h want %h", a_wr_conflict, exp_v); end
        @(negedge clk);
        idle(); a_rd_addr = 8'h87;
        q.push_back(64'h0); q.push_back({32'h22, 32'h11});
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_wr_conflict) !== exp_v) begin miscompares++; $display("FAIL distinct_addr_conflict got %h want %h", a_wr_conflict, exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (a_rd_data !== exp_v) begin miscompares++; $display("FAIL distinct_addr_data got %h want %h", a_rd_data, exp_v); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle(); a_rsv_en = 1'b1; a_rsv_addr = 4'd4; a_rd_addr = 8'h40;
        q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_rd_busy) !== exp_v) begin miscompares++; $display("FAIL rsv_busy_early got %h want %h", a_rd_busy, exp_v); end
        @(negedge clk);
        idle(); a_rd_addr = 8'h40;
        a_wr_en = 2'b01; a_wr_addr = 8'h04; a_wr_clr = 2'b01; a_wr_data = 64'hAA;
        q.push_back(64'h0010); q.push_back(64'h2); q.push_back(64'hAA);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_busy_vec) !== exp_v) begin miscompares++; $display("FAIL rsv_busy_vec got %h want %h", a_busy_vec, exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(a_rd_busy) !== exp_v) begin miscompares++; $display("FAIL rsv_rd_busy got %h want %h", a_rd_busy, exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(a_rd_data[63:32]) !== exp_v) begin miscompares++; $display("FAIL clr_write_bypass got %h want %h", a_rd_data[63:32], exp_v); end
        @(negedge clk);
        idle(); a_rsv_en = 1'b1; a_rsv_addr = 4'd4;
        q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_busy_vec) !== exp_v) begin miscompares++; $display("FAIL clr_busy got %h want %h", a_busy_vec, exp_v); end
        @(negedge clk);
        idle(); a_rsv_en = 1'b1; a_rsv_addr = 4'd4;
        a_wr_en = 2'b01; a_wr_addr = 8'h04; a_wr_clr = 2'b01;
        q.push_back(64'h0010);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_busy_vec) !== exp_v) begin miscompares++; $display("FAIL rerserve_busy got %h want %h", a_busy_vec, exp_v); end
        @(negedge clk);
        idle(); a_wr_en = 2'b11; a_wr_addr = 8'h44; a_wr_clr = 2'b01;
        q.push_back(64'h0010);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_busy_vec) !== exp_v) begin miscompares++; $display("FAIL rsv_and_clr got %h want %h", a_busy_vec, exp_v); end
        @(negedge clk);
        idle(); a_wr_en = 2'b11; a_wr_addr = 8'h44; a_wr_clr = 2'b10;
        q.push_back(64'h0010);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_busy_vec) !== exp_v) begin miscompares++; $display("FAIL clr_loser_port got %h want %h", a_busy_vec, exp_v); end
        @(negedge clk);
        idle();
        q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(a_busy_vec) !== exp_v) begin miscompares++; $display("FAIL clr_winner_port got %h want %h", a_busy_vec, exp_v); end
    endtask

    task automatic test_zero();
        @(negedge clk);
        idle();
        c_wr_en = 3'b001; c_wr_addr = 12'h000; c_wr_data = 48'hFFFF; c_wr_clr = 3'b001;
        c_rsv_en = 1'b1; c_rsv_addr = 4'd0; c_rd_addr = 16'h0000;
        q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (c_rd_data !== exp_v) begin miscompares++; $display("FAIL zero_no_forward got %h want %h", c_rd_data, exp_v); end
        @(negedge clk);
        idle();
        q.push_back(64'h0); q.push_back(64'h0); q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (c_rd_data !== exp_v) begin miscompares++; $display("FAIL zero_read got %h want %h", c_rd_data, exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(c_busy_vec) !== exp_v) begin miscompares++; $display("FAIL zero_busy got %h want %h", c_busy_vec, exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(c_rd_busy) !== exp_v) begin miscompares++; $display("FAIL zero_rd_busy got %h want %h", c_rd_busy, exp_v); end
    endtask

    task automatic test_range();
        @(negedge clk);
        idle();
        c_wr_en = 3'b111; c_wr_addr = 12'hDDD; c_wr_data = {3{16'hABCD}}; c_wr_clr = 3'b111;
        c_rsv_en = 1'b1; c_rsv_addr = 4'd13; c_rd_addr = 16'hD000;
        q.push_back(64'h0); q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(c_rd_data[63:48]) !== exp_v) begin miscompares++; $display("FAIL range_bypass got %h want %h", c_rd_data[63:48], exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(c_rd_busy) !== exp_v) begin miscompares++; $display("FAIL range_rd_busy got %h want %h", c_rd_busy, exp_v); end
        @(negedge clk);
        idle(); c_rd_addr = 16'hD000;
        q.push_back(64'h0); q.push_back(64'h0); q.push_back(64'h0);
        #1;
        exp_v = q.pop_front(); vectors++;
        if (64'(c_rd_data[63:48]) !== exp_v) begin miscompares++; $display("FAIL range_read got %h want %h", c_rd_data[63:48], exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(c_busy_vec) !== exp_v) begin miscompares++; $display("FAIL range_busy got %h want %h", c_busy_vec, exp_v); end
        exp_v = q.pop_front(); vectors++;
        if (64'(c_wr_conflict) !== exp_v) begin miscompares++; $display("FAIL range_conflict got %h want %h", c_wr_conflict, exp_v); end
    endtask

    task automatic test_random();
        logic [63:0] exp_d;
        logic [3:0]  exp_b, a, wa, wb;
        logic [15:0] d;
        logic [11:0] set, clr;
        logic        conf;
        for (int i = 0; i < 12; i++) m_mem[i] = '0;
        m_busy = '0; m_conf = 1'b0;
        for (int n = 0; n < 1003; n++) begin
            @(negedge clk);
            idle();
            if (n < 1000) begin
                c_wr_en = 3'($urandom); c_wr_clr = 3'($urandom); c_wr_data = {16'($urandom), 32'($urandom)};
                for (int w = 0; w < 3; w++) c_wr_addr[w*4 +: 4] = 4'($urandom_range(0, 13));
                for (int p = 0; p < 4; p++) c_rd_addr[p*4 +: 4] = 4'($urandom_range(0, 13));
                c_rsv_en = ($urandom_range(0, 2) == 0); c_rsv_addr = 4'($urandom_range(0, 13));
            end else begin
                for (int p = 0; p < 4; p++) c_rd_addr[p*4 +: 4] = 4'((n - 1000) * 4 + p);
            end
            exp_d = '0; exp_b = '0;
            for (int p = 0; p < 4; p++) begin
                a = c_rd_addr[p*4 +: 4];
                if (a < 4'd12 && a != 4'd0) begin
                    d = m_mem[a];
                    for (int w = 0; w < 3; w++)
                        if (c_wr_en[w] && c_wr_addr[w*4 +: 4] == a) d = c_wr_data[w*16 +: 16];
                    exp_d[p*16 +: 16] = d;
                    exp_b[p] = m_busy[a];
                end
            end
            q.push_back(exp_d); q.push_back(64'(exp_b)); q.push_back(64'(m_busy)); q.push_back(64'(m_conf));
            #1;
            exp_v = q.pop_front(); vectors++;
            if (c_rd_data !== exp_v) begin miscompares++; $display("FAIL rand_rd_data cyc %0d got %h want %h", n, c_rd_data, exp_v); end
            exp_v = q.pop_front(); vectors++;
            if (64'(c_rd_busy) !== exp_v) begin miscompares++; $display("FAIL rand_rd_busy cyc %0d got %h want %h", n, c_rd_busy, exp_v); end
            exp_v = q.pop_front(); vectors++;
            if (64'(c_busy_vec) !== exp_v) begin miscompares++; $display("FAIL rand_busy_vec cyc %0d got %h want %h", n, c_busy_vec, exp_v); end
            exp_v = q.pop_front(); vectors++;
            if (64'(c_wr_conflict) !== exp_v) begin miscompares++; $display("FAIL rand_conflict cyc %0d got %h want %h", n, c_wr_conflict, exp_v); end
            conf = 1'b0; set = '0; clr = '0;
            for (int w = 0; w < 3; w++)
                for (int v = w + 1; v < 3; v++) begin
                    wa = c_wr_addr[w*4 +: 4]; wb = c_wr_addr[v*4 +: 4];
                    if (c_wr_en[w] && c_wr_en[v] && wa < 4'd12 && wa == wb) conf = 1'b1;
                end
            if (c_rsv_en && c_rsv_addr < 4'd12 && c_rsv_addr != 4'd0) set[c_rsv_addr] = 1'b1;
            for (int w = 0; w < 3; w++) begin
                wa = c_wr_addr[w*4 +: 4];
                if (c_wr_en[w] && wa < 4'd12 && wa != 4'd0) begin
                    m_mem[wa] = c_wr_data[w*16 +: 16];
                    clr[wa] = c_wr_clr[w];
                end
            end
            m_busy = (m_busy | set) & ~(clr & ~set);
            m_conf = conf;
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_zero();
        test_range();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
